// File: rtl/song_pkg.sv
// Shared types and song-word field layout for the play-mode sequencer.
// Words are {beats[3:0], notes[7:0] one-hot, shift[1:0]}; a zero beat count marks end of song.
package song_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int SONG_WORD_W = 14;
  localparam int NOTE_W      = 10;
  localparam int BEATS_MSB   = 13;
  localparam int BEATS_LSB   = 10;
  localparam int NOTES_MSB   = 9;
  localparam int NOTES_LSB   = 2;
  localparam int SHIFT_MSB   = 1;
  localparam int SHIFT_LSB   = 0;

  localparam logic [3:0] END_BEATS = 4'd0;

  function automatic logic [3:0] word_beats(input logic [SONG_WORD_W-1:0] word);
    return word[BEATS_MSB:BEATS_LSB];
  endfunction

  function automatic logic [NOTE_W-1:0] word_note(input logic [SONG_WORD_W-1:0] word);
    return {word[NOTES_MSB:NOTES_LSB], word[SHIFT_MSB:SHIFT_LSB]};
  endfunction

endpackage

// File: rtl/song_play_ctrl_beat_timer.sv
// Note duration timer: prescaler (0..TICKS_PER_BEAT-1) feeding a 4-bit beat down-counter.
// Flags the last active cycle of a note and the articulation-gap window at its tail.
module beat_timer #(
  parameter int TICKS_PER_BEAT = 25000000,
  parameter int GAP_CYC        = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] beats,
  input  logic       en,
  output logic       last,
  output logic       gap_now,
  output logic       gap_next
);

  localparam int PRE_W = $clog2(TICKS_PER_BEAT);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_BEAT - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       beat_q, beat_d;

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      beat_q <= 4'd0;
    end else begin
      pre_q  <= pre_d;
      beat_q <= beat_d;
    end
  end

  // Load / advance / hold
  always_comb begin
    pre_d  = pre_q;
    beat_d = beat_q;
    if (load) begin
      pre_d  = '0;
      beat_d = beats;
    end else if (en) begin
      if (pre_q == PRE_MAX) begin
        pre_d  = '0;
        beat_d = beat_q - 4'd1;
      end else begin
        pre_d  = pre_q + PRE_W'(1);
      end
    end else begin
      pre_d  = pre_q;
    end
  end

  assign last = en && (beat_q == 4'd1) && (pre_q == PRE_MAX);

  // gap_now: the current cycle lies in the tail window; gap_next: the following one will.
  assign gap_now  = (beat_q == 4'd1) && (int'(pre_q) >= (TICKS_PER_BEAT - GAP_CYC));
  assign gap_next = (beat_q == 4'd1) && (int'(pre_q) >= (TICKS_PER_BEAT - GAP_CYC - 1))
                    && (pre_q != PRE_MAX);

endmodule

// File: rtl/song_play_ctrl.sv
// Play-mode sequencer: fetches song words over a req/valid read port and holds each note
// for its beat count. Define ARTIC_GAP_EN to silence the tail GAP_CYC cycles of each note.
module song_play_ctrl
  import song_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int TICKS_PER_BEAT = 25000000,
  parameter int GAP_CYC        = 2500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic [ADDR_W-1:0] song_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [13:0]       rd_data,
  output logic [9:0]        note_out,
  output logic              busy,
  output logic              done
);

`ifdef ARTIC_GAP_EN
  localparam logic GAP_ON = 1'b1;
`else
  localparam logic GAP_ON = 1'b0;
`endif

  state_e              state_q, state_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [NOTE_W-1:0]   note_out_q, note_out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                tmr_load, tmr_en, tmr_last, gap_now, gap_next;
  logic [3:0]          rd_beats;
  logic                last_addr;

  assign rd_beats  = word_beats(rd_data);
  assign last_addr = (rd_addr_q == {ADDR_W{1'b1}});
  assign tmr_en    = (state_q == ST_PLAY);

  beat_timer #(
    .TICKS_PER_BEAT (TICKS_PER_BEAT),
    .GAP_CYC        (GAP_CYC)
  ) u_beat_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .beats    (rd_beats),
    .en       (tmr_en),
    .last     (tmr_last),
    .gap_now  (gap_now),
    .gap_next (gap_next)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      note_q     <= '0;
      note_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      note_q     <= note_d;
      note_out_q <= note_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; stop overrides everything
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = start ? ST_FETCH : ST_IDLE;
        ST_FETCH: begin
          if (!rd_valid)                  state_d = ST_FETCH;
          else if (rd_beats == END_BEATS) state_d = ST_DONE;
          else if (pause)                 state_d = ST_PAUSE;
          else                            state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (tmr_last)   state_d = last_addr ? ST_DONE : ST_FETCH;
          else if (pause) state_d = ST_PAUSE;
          else            state_d = ST_PLAY;
        end
        ST_PAUSE: state_d = pause ? ST_PAUSE : ST_PLAY;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Next register values for the read port, note path and status
  always_comb begin
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    note_d     = note_q;
    note_out_d = note_out_q;
    tmr_load   = 1'b0;
    if (stop) begin
      rd_en_d    = 1'b0;
      note_out_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rd_addr_d  = song_base;
            rd_en_d    = 1'b1;
            note_out_d = '0;
          end else begin
            rd_en_d    = 1'b0;
          end
        end
        ST_FETCH: begin
          // Previous note keeps sounding until the next word lands.
          if (rd_valid) begin
            rd_en_d = 1'b0;
            if (rd_beats == END_BEATS) begin
              note_out_d = '0;
            end else begin
              tmr_load   = 1'b1;
              note_d     = word_note(rd_data);
              note_out_d = pause ? '0 : word_note(rd_data);
            end
          end else begin
            rd_en_d = 1'b1;
          end
        end
        ST_PLAY: begin
          if (tmr_last) begin
            if (last_addr) begin
              note_out_d = '0;
            end else begin
              rd_addr_d = rd_addr_q + ADDR_W'(1);
              rd_en_d   = 1'b1;
            end
          end else if (pause) begin
            note_out_d = '0;
          end else begin
            note_out_d = (GAP_ON && gap_next) ? '0 : note_q;
          end
        end
        ST_PAUSE: begin
          if (pause) note_out_d = '0;
          else       note_out_d = (GAP_ON && gap_now) ? '0 : note_q;
        end
        ST_DONE:  note_out_d = '0;
        default: begin
          rd_en_d    = 1'b0;
          note_out_d = '0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign note_out = note_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_song_play_ctrl.sv
// Directed bench for song_play_ctrl with a 2-cycle-latency song memory model.
// Expectations follow ARTIC_GAP_EN when the macro is defined for the build.
module tb_song_play_ctrl;

  localparam int ADDR_W = 8;
  localparam int TPB    = 4;
  localparam int GAPC   = 1;
  localparam int LAT    = 2;
`ifdef ARTIC_GAP_EN
  localparam int GAP_SEEN = GAPC;
`else
  localparam int GAP_SEEN = 0;
`endif

  logic              clk = 1'b0;
  logic              rst, start, pause, stop;
  logic [ADDR_W-1:0] song_base;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [13:0]       rd_data;
  logic [9:0]        note_out;
  logic              busy, done;

  logic [13:0]       mem [0:255];
  int                tests = 0;
  int                fails = 0;
  bit                pend;
  int                cnt;
  logic [7:0]        paddr;

  always #5 clk = ~clk;

  song_play_ctrl #(
    .ADDR_W         (ADDR_W),
    .TICKS_PER_BEAT (TPB),
    .GAP_CYC        (GAPC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .song_base (song_base),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .note_out  (note_out),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; then memory model answers a captured request LAT cycles later.
  task automatic step();
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
    if (pend) begin
      cnt++;
      if (cnt == LAT - 1) begin
        rd_valid = 1'b1;
        rd_data  = mem[paddr];
        pend     = 1'b0;
      end
    end else if (rd_en) begin
      pend  = 1'b1;
      paddr = rd_addr;
      cnt   = 0;
    end
  endtask

  task automatic run_song(input logic [9:0] nv, output int ncnt, output int dcnt, output int idle_ok);
    ncnt = 0; dcnt = 0; idle_ok = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (note_out == nv && !rd_en) ncnt++;
      if (done) dcnt++;
      if (!busy) begin
        idle_ok = 1;
        break;
      end
    end
  endtask

  initial begin
    int n, n2, d, ok, z, bad;
    for (int i = 0; i < 256; i++) mem[i] = 14'h0;
    mem[8'h10] = 14'h0805;  mem[8'h11] = 14'h0000;
    mem[8'h20] = 14'h0805;  mem[8'h21] = 14'h0000;
    mem[8'h30] = 14'h0805;
    mem[8'hFE] = 14'h0408;  mem[8'hFF] = 14'h0410;
    mem[8'h60] = 14'h0408;  mem[8'h61] = 14'h0000;
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; song_base = 8'h00;
    rd_valid = 1'b0; rd_data = 14'h0; pend = 1'b0; cnt = 0; paddr = 8'h00;
    step(); step();
    rst = 1'b0;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_note", note_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // 1: basic two-beat note then end marker
    song_base = 8'h10; start = 1'b1; step(); start = 1'b0;
    chk("t1_rd_en", rd_en, 1);
    chk("t1_rd_addr", rd_addr, 32'h10);
    chk("t1_busy", busy, 1);
    chk("t1_first_note", note_out, 0);
    run_song(10'h005, n, d, ok);
    chk("t1_note_cycles", n, 8 - GAP_SEEN);
    chk("t1_done_pulses", d, 1);
    chk("t1_idle", ok, 1);
    chk("t1_end_addr", rd_addr, 32'h11);
    chk("t1_note_end", note_out, 0);

    // 2: pause for 3 cycles mid-note
    song_base = 8'h20; start = 1'b1; step(); start = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && n < 3; i++) begin
      step();
      if (note_out == 10'h005 && !rd_en) n++;
    end
    pause = 1'b1; z = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (note_out == 10'h000) z++;
    end
    pause = 1'b0;
    chk("t2_pause_silent", z, 3);
    run_song(10'h005, n2, d, ok);
    chk("t2_note_cycles", n + n2, 8 - GAP_SEEN);
    chk("t2_done_pulses", d, 1);

    // 3: stop during fetch, late rd_valid ignored
    song_base = 8'h30; start = 1'b1; step(); start = 1'b0;
    chk("t3_fetching", rd_en, 1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t3_rd_en", rd_en, 0);
    chk("t3_busy", busy, 0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || busy || rd_en || note_out != 10'h000) bad++;
    end
    chk("t3_quiet", bad, 0);

    // 4: start+stop together, then start during PLAY
    song_base = 8'h10; start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("t4_ss_busy", busy, 0);
    chk("t4_ss_rd_en", rd_en, 0);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 20 && note_out != 10'h005; i++) step();
    chk("t4_playing", note_out, 32'h005);
    song_base = 8'h50; start = 1'b1;
    step(); step(); step();
    start = 1'b0;
    chk("t4_no_restart_en", rd_en, 0);
    chk("t4_no_restart_addr", rd_addr, 32'h10);
    run_song(10'h005, n, d, ok);
    chk("t4_done_pulses", d, 1);
    chk("t4_end_addr", rd_addr, 32'h11);

    // 5: song runs to top of memory with no end marker
    song_base = 8'hFE; start = 1'b1; step(); start = 1'b0;
    run_song(10'h010, n, d, ok);
    chk("t5_last_note", n, 4 - GAP_SEEN);
    chk("t5_done_pulses", d, 1);
    chk("t5_no_wrap", rd_addr, 32'hFF);

    // 6: one-beat note articulation
    song_base = 8'h60; start = 1'b1; step(); start = 1'b0;
    run_song(10'h008, n, d, ok);
    chk("t6_note_cycles", n, 4 - GAP_SEEN);
    chk("t6_idle", ok, 1);

    // reset mid-song
    song_base = 8'h10; start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("mrst_rd_en", rd_en, 0);
    chk("mrst_rd_addr", rd_addr, 0);
    chk("mrst_note", note_out, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
